// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants and types for the four-digit seven-segment scanner.
//   seg_t        : segment vector {g,f,e,d,c,b,a}, active low
//   an_t         : anode enable vector, active low, an[0] = s1 .. an[3] = m10
//   digit_idx_t  : which digit slot is being driven
//   SEG_0..SEG_9 : glyphs for decimal digits
//   SEG_DASH     : glyph for a nibble that cannot be a valid time digit
//   SEG_OFF      : all segments dark
//   AN_OFF       : all anodes disabled
// -----------------------------------------------------------------------------
package seg7_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] an_t;

    typedef enum logic [1:0] {
        DIG_S1  = 2'd0,
        DIG_S10 = 2'd1,
        DIG_M1  = 2'd2,
        DIG_M10 = 2'd3
    } digit_idx_t;

    localparam seg_t SEG_0    = 7'h40;
    localparam seg_t SEG_1    = 7'h79;
    localparam seg_t SEG_2    = 7'h24;
    localparam seg_t SEG_3    = 7'h30;
    localparam seg_t SEG_4    = 7'h19;
    localparam seg_t SEG_5    = 7'h12;
    localparam seg_t SEG_6    = 7'h02;
    localparam seg_t SEG_7    = 7'h78;
    localparam seg_t SEG_8    = 7'h00;
    localparam seg_t SEG_9    = 7'h10;
    localparam seg_t SEG_DASH = 7'h3F;
    localparam seg_t SEG_OFF  = 7'h7F;

    localparam an_t  AN_OFF   = 4'hF;

endpackage

// File: rtl/seg7_if.sv
// -----------------------------------------------------------------------------
// seg7_if
// Bundle between the timer side and the display scanner.
//   bcd_in   : timer value {m10,m1,s10,s1}, asynchronous to the scanner clock
//   mode     : 1 = countdown (colon blinks), 0 = count-up (colon steady)
//   blink_en : allow whole-display blinking once the value reaches 0000
//   an       : anode enables, active low
//   seg      : segments {g,f,e,d,c,b,a}, active low
//   dp       : decimal point / colon, active low
// master = timer/board side, slave = scanner.
// -----------------------------------------------------------------------------
interface seg7_if;
    import seg7_pkg::*;

    logic [15:0] bcd_in;
    logic        mode;
    logic        blink_en;
    an_t         an;
    seg_t        seg;
    logic        dp;

    modport master (output bcd_in, mode, blink_en, input an, seg, dp);
    modport slave  (input bcd_in, mode, blink_en, output an, seg, dp);

endinterface

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational BCD nibble to seven-segment glyph.
//   nibble    in  4  digit value
//   tens_flag in  1  digit is a tens position (s10/m10), valid range 0..5
//   seg       out 7  active-low glyph; dash for out-of-range nibbles
// -----------------------------------------------------------------------------
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       tens_flag,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_DASH;
        if ((nibble <= 4'd9) && !(tens_flag && (nibble > 4'd5))) begin
            case (nibble)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan.sv
// -----------------------------------------------------------------------------
// seg7_scan
// Time-multiplexes a BCD MM:SS value onto a common-anode 4-digit display with
// input stabilisation, per-slot anti-ghost blanking, leading-zero blanking of
// m10 and whole-display blinking at expiry.
//   clk    in  1  system clock
//   rst_n  in  1  asynchronous active-low reset
//   bus    seg7_if.slave : bcd_in, mode, blink_en in; an, seg, dp out
// Parameters:
//   SCAN_DIV    clk cycles per digit slot (>= 2)
//   BLANK_CYC   leading cycles of each slot with all anodes off (< SCAN_DIV)
//   BLINK_TICKS slot ticks per blink half-period (>= 1)
//   LZB         1 = blank m10 when it is zero
// -----------------------------------------------------------------------------
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int BLANK_CYC   = 500,
    parameter int BLINK_TICKS = 250,
    parameter bit LZB         = 1'b1
) (
    input  logic   clk,
    input  logic   rst_n,
    seg7_if.slave  bus
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = $clog2(BLINK_TICKS + 1);

    localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PRE_BLANK  = PW'(BLANK_CYC);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    logic [15:0]   sync_p0;
    logic [15:0]   sync_p1;
    logic [15:0]   stable_val;
    logic [15:0]   snap;
    logic [PW-1:0] pre;
    digit_idx_t    idx;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    an_t           an_r;
    seg_t          seg_r;
    logic          dp_r;

    logic          tick;
    logic [3:0]    nib;
    seg_t          glyph;
    logic          blank;
    an_t           an_next;
    seg_t          seg_next;
    logic          dp_next;

    assign tick = (pre == PRE_LAST);

    // Stage p0/p1: two-flop synchroniser, then a filter that only accepts a
    // value seen on two consecutive clocks so a single-cycle transient is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0    <= '0;
            sync_p1    <= '0;
            stable_val <= '0;
        end else begin
            sync_p0 <= bus.bcd_in;
            sync_p1 <= sync_p0;
            if (sync_p0 == sync_p1) begin
                stable_val <= sync_p1;
            end
        end
    end

    // Scan timing: prescaler, digit index, frame snapshot and blink phase.
    // The snapshot is taken only when leaving the last digit, so every frame
    // shows one coherent value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre         <= '0;
            idx         <= DIG_S1;
            snap        <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            pre <= tick ? '0 : pre + PW'(1);
            if (tick) begin
                idx <= digit_idx_t'(idx + 2'd1);
                if (idx == DIG_M10) begin
                    snap <= stable_val;
                end
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end
        end
    end

    always_comb begin
        nib = snap[3:0];
        case (idx)
            DIG_S1:  nib = snap[3:0];
            DIG_S10: nib = snap[7:4];
            DIG_M1:  nib = snap[11:8];
            DIG_M10: nib = snap[15:12];
        endcase
    end

    // Tens positions (s10, m10) sit on odd indices.
    seg7_decode u_decode (
        .nibble    (nib),
        .tens_flag (idx[0]),
        .seg       (glyph)
    );

    always_comb begin
        blank = (pre < PRE_BLANK)
              | (bus.blink_en & (snap == 16'h0000) & blink_phase)
              | (LZB & (idx == DIG_M10) & (snap[15:12] == 4'd0));
        an_next  = AN_OFF;
        seg_next = SEG_OFF;
        dp_next  = 1'b1;
        if (!blank) begin
            an_next  = ~(4'b0001 << idx);
            seg_next = glyph;
            // Colon: steady when counting up, follows blink phase when counting down.
            dp_next  = !((idx == DIG_S10) && (!bus.mode || !blink_phase));
        end
    end

    // Output stage: one clock behind index/prescaler, glitch-free pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_r  <= AN_OFF;
            seg_r <= SEG_OFF;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= an_next;
            seg_r <= seg_next;
            dp_r  <= dp_next;
        end
    end

    assign bus.an  = an_r;
    assign bus.seg = seg_r;
    assign bus.dp  = dp_r;

endmodule

// File: tb/tb_seg7_scan.sv
`timescale 1ns/1ps
module tb_seg7_scan;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7_if if0 ();
    seg7_if if1 ();

    assign if1.bcd_in   = if0.bcd_in;
    assign if1.mode     = if0.mode;
    assign if1.blink_en = if0.blink_en;

    // dut0: default test settings; dut1: no leading-zero blanking, blink
    // half-period of 3 slots so the colon visibly changes on its slot.
    seg7_scan #(.SCAN_DIV(4), .BLANK_CYC(1), .BLINK_TICKS(2), .LZB(1'b1)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    seg7_scan #(.SCAN_DIV(4), .BLANK_CYC(1), .BLINK_TICKS(3), .LZB(1'b0)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    localparam logic [11:0] OFF_ALL = {4'hF, 7'h7F, 1'b1};

    int total = 0;
    int bad   = 0;
    int cyc;

    typedef struct {
        int          k;
        int          d;
        int          f;
        logic [11:0] e;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%03h want=%03h", tag, got, want);
        end
    endtask

    // Output cycle k = number of clock edges since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [6:0] seg_of(input logic [3:0] n, input bit tens);
        if (n > 4'd9 || (tens && n > 4'd5)) return 7'h3F;
        case (n)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            default: return 7'h10;
        endcase
    endfunction

    // Expected pins after edge k for a frame whose snapshot is v.
    // Output k reflects prescaler (k-1)%4 and global slot number (k-1)/4.
    function automatic logic [11:0] model(input int k, input logic [15:0] v, input bit lzb,
                                          input int bt, input bit md, input bit be);
        int         s;
        int         p;
        int         ix;
        bit         ph;
        logic [3:0] nib;
        logic [3:0] one;
        logic [3:0] an;
        logic       dp;
        s   = (k - 1) / 4;
        p   = (k - 1) % 4;
        ix  = s % 4;
        ph  = ((s / bt) % 2) == 1;
        nib = v[ix*4 +: 4];
        if (p < 1 || (be && v == 16'h0 && ph) || (lzb && ix == 3 && v[15:12] == 4'd0))
            return OFF_ALL;
        one = 4'b0001;
        an  = ~(one << ix);
        dp  = (ix == 1 && (!md || !ph)) ? 1'b0 : 1'b1;
        return {an, seg_of(nib, (ix % 2) == 1), dp};
    endfunction

    task automatic push_frame(input int f, input logic [15:0] v, input bit md, input bit be);
        for (int k = 16*f + 1; k <= 16*f + 16; k++) begin
            sb.push_back('{k, 0, f, model(k, v, 1'b1, 2, md, be)});
            sb.push_back('{k, 1, f, model(k, v, 1'b0, 3, md, be)});
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Drive a new value and return the first frame guaranteed to show it.
    task automatic set_val(input logic [15:0] v, output int f);
        if0.bcd_in = v;
        f = (cyc + 4 + 15) / 16;
    endtask

    exp_t        e;
    logic [11:0] got;
    always @(negedge clk) begin
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].k <= cyc) begin
                e = sb.pop_front();
                if (e.k < cyc) begin
                    check($sformatf("sb_late k=%0d", e.k), 12'(cyc), 12'(e.k));
                end else begin
                    got = (e.d == 0) ? {if0.an, if0.seg, if0.dp} : {if1.an, if1.seg, if1.dp};
                    check($sformatf("frame%0d k%0d dut%0d", e.f, e.k, e.d), got, e.e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int f;
        int x;
        if0.bcd_in   = 16'h0000;
        if0.mode     = 1'b0;
        if0.blink_en = 1'b0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dut0", {if0.an, if0.seg, if0.dp}, OFF_ALL);
        check("rst_dut1", {if1.an, if1.seg, if1.dp}, OFF_ALL);

        // Release: frame 0 shows snap=0000, first lit cycle is k=2 on s1.
        rst_n = 1'b1;
        push_frame(0, 16'h0000, 1'b0, 1'b0);
        wait_cyc(16);

        // Static value, first and third frame after it settles.
        set_val(16'h1259, f);
        push_frame(f, 16'h1259, 1'b0, 1'b0);
        push_frame(f + 2, 16'h1259, 1'b0, 1'b0);
        wait_cyc(16*(f + 3));

        // Countdown mode: colon follows blink phase.
        if0.mode = 1'b1;
        set_val(16'h0130, f);
        for (int i = 0; i < 3; i++) push_frame(f + i, 16'h0130, 1'b1, 1'b0);
        wait_cyc(16*(f + 3));
        if0.mode = 1'b0;

        // Leading zero and invalid tens nibble.
        set_val(16'h07A3, f);
        push_frame(f, 16'h07A3, 1'b0, 1'b0);
        push_frame(f + 1, 16'h07A3, 1'b0, 1'b0);
        wait_cyc(16*(f + 2));

        // Expiry blink, then steady zero once blinking is disabled.
        if0.blink_en = 1'b1;
        set_val(16'h0000, f);
        push_frame(f, 16'h0000, 1'b0, 1'b1);
        push_frame(f + 1, 16'h0000, 1'b0, 1'b1);
        wait_cyc(16*(f + 2));
        if0.blink_en = 1'b0;
        push_frame(f + 2, 16'h0000, 1'b0, 1'b0);
        wait_cyc(16*(f + 3));

        // Mid-frame change: current frame keeps the old value.
        set_val(16'h0159, f);
        push_frame(f, 16'h0159, 1'b0, 1'b0);
        push_frame(f + 1, 16'h0159, 1'b0, 1'b0);
        push_frame(f + 2, 16'h0200, 1'b0, 1'b0);
        wait_cyc(16*(f + 1) + 5);
        if0.bcd_in = 16'h0200;
        wait_cyc(16*(f + 3));

        // One-cycle pulse straddling the snapshot edge is never shown.
        x = f + 3;
        for (int i = 0; i < 3; i++) push_frame(x + i, 16'h0200, 1'b0, 1'b0);
        wait_cyc(16*(x + 1) - 2);
        if0.bcd_in = 16'h0999;
        @(negedge clk);
        if0.bcd_in = 16'h0200;
        wait_cyc(16*(x + 3));

        // Asynchronous reset in the middle of a lit slot 2.
        set_val(16'h1259, f);
        push_frame(f, 16'h1259, 1'b0, 1'b0);
        wait_cyc(16*(f + 1) + 10);
        check("pre_rst_dut0", {if0.an, if0.seg, if0.dp}, model(cyc, 16'h1259, 1'b1, 2, 1'b0, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_dut0", {if0.an, if0.seg, if0.dp}, OFF_ALL);
        check("async_rst_dut1", {if1.an, if1.seg, if1.dp}, OFF_ALL);
        check("sb_drained", 12'(sb.size()), 12'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
